// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect/stall control, instruction memory port and decode-side outputs.
// master = fetch stage, slave = surrounding pipeline/memory.
interface fetch_stage_if #(parameter int IMEM_AW = 11);
  logic               isStall;
  logic               redirectEn;
  logic [31:0]        redirectPC;
  logic [IMEM_AW-1:0] imemAddr;
  logic [31:0]        imemData;
  logic [31:0]        outInst;
  logic [31:0]        outPC;
  logic [31:0]        outPCPlus4;
  logic               outValid;
  logic [1:0]         fetchState;
  logic [31:0]        stallCycles;
  logic [31:0]        bubbleCycles;

  modport master (
    input  isStall, redirectEn, redirectPC, imemData,
    output imemAddr, outInst, outPC, outPCPlus4, outValid, fetchState,
           stallCycles, bubbleCycles
  );

  modport slave (
    output isStall, redirectEn, redirectPC, imemData,
    input  imemAddr, outInst, outPC, outPCPlus4, outValid, fetchState,
           stallCycles, bubbleCycles
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, synchronous imem request, one-entry skid for stalls, redirect bubble.
// Optional stall/bubble counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          IMEM_AW     = 11
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, STALL = 2'd2, BUBBLE = 2'd3} state_e;

  logic [31:0] pc_q, pc_d, resp_pc_q, resp_pc_d, skid_inst_q, skid_inst_d;
  logic        resp_valid_q, resp_valid_d, skid_full_q, skid_full_d;
  state_e      state_q, state_d;
  logic        unused_ok;

  always_comb begin
    pc_d         = pc_q;
    resp_pc_d    = resp_pc_q;
    resp_valid_d = resp_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_full_d  = skid_full_q;
    state_d      = state_q;
    if (bus.redirectEn) begin
      pc_d         = {bus.redirectPC[31:2], 2'b00};
      resp_valid_d = 1'b0;
      skid_full_d  = 1'b0;
      state_d      = BUBBLE;
    end else if (bus.isStall) begin
      // memory rereads pcReg while held, so capture the live response once
      if (resp_valid_q && !skid_full_q) begin
        skid_inst_d = bus.imemData;
        skid_full_d = 1'b1;
      end
      if (resp_valid_q) state_d = STALL;
    end else begin
      resp_pc_d    = pc_q;
      resp_valid_d = 1'b1;
      skid_full_d  = 1'b0;
      pc_d         = pc_q + 32'd4;
      state_d      = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VALUE;
      resp_pc_q    <= 32'h0;
      resp_valid_q <= 1'b0;
      skid_inst_q  <= 32'h0;
      skid_full_q  <= 1'b0;
      state_q      <= BOOT;
    end else begin
      pc_q         <= pc_d;
      resp_pc_q    <= resp_pc_d;
      resp_valid_q <= resp_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_full_q  <= skid_full_d;
      state_q      <= state_d;
    end
  end

  assign bus.imemAddr   = pc_q[IMEM_AW+1:2];
  assign bus.outInst    = skid_full_q ? skid_inst_q : bus.imemData;
  assign bus.outPC      = resp_pc_q;
  assign bus.outPCPlus4 = resp_pc_q + 32'd4;
  assign bus.outValid   = resp_valid_q;
  assign bus.fetchState = state_q;
  assign unused_ok      = ^bus.redirectPC[1:0];

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.isStall && !bus.redirectEn) stall_cnt_d = stall_cnt_q + 32'd1;
    if (state_q == BUBBLE)              bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.stallCycles  = stall_cnt_q;
  assign bus.bubbleCycles = bubble_cnt_q;
`else
  assign bus.stallCycles  = 32'h0;
  assign bus.bubbleCycles = 32'h0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns its word address as the instruction.
// A second instance with RESET_VALUE=FFFF_FFFC covers PC and imemAddr wrap.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fetch_stage_if #(.IMEM_AW(11)) b0 ();
  fetch_stage_if #(.IMEM_AW(11)) b1 ();

  fetch_stage #(.RESET_VALUE(32'h0), .IMEM_AW(11)) dut (.clk(clk), .reset(reset), .bus(b0));
  fetch_stage #(.RESET_VALUE(32'hFFFF_FFFC), .IMEM_AW(11)) dut_wrap (.clk(clk), .reset(reset), .bus(b1));

  always @(posedge clk) b0.imemData <= {21'h0, b0.imemAddr};
  always @(posedge clk) b1.imemData <= {21'h0, b1.imemAddr};

`ifdef FETCH_PERF_EN
  localparam logic [31:0] EXP_STALLS  = 32'd5;
  localparam logic [31:0] EXP_BUBBLES = 32'd1;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_BUBBLES = 32'd0;
`endif

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    b0.isStall = 0; b0.redirectEn = 0; b0.redirectPC = 0;
    b1.isStall = 0; b1.redirectEn = 0; b1.redirectPC = 0;
    reset = 0;
    #1;
    tests++; if (b0.outValid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0d want 0", b0.outValid); end
    tests++; if (b0.outPC !== 32'h0) begin fails++; $display("FAIL rst_pc got %h want 0", b0.outPC); end
    tests++; if (b0.fetchState !== 2'd0) begin fails++; $display("FAIL rst_state got %0d want 0", b0.fetchState); end
    tests++; if (b0.imemAddr !== 11'd0) begin fails++; $display("FAIL rst_addr got %0d want 0", b0.imemAddr); end
    tests++; if (b0.stallCycles !== 32'h0 || b0.bubbleCycles !== 32'h0) begin fails++; $display("FAIL rst_cnt got %0d/%0d want 0/0", b0.stallCycles, b0.bubbleCycles); end
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1;
  endtask

  task automatic test_run();
    tick();
    tests++; if (b0.outValid !== 1'b1 || b0.outPC !== 32'h0 || b0.outInst !== 32'h0) begin fails++; $display("FAIL run0 got v%0d pc %h inst %h want v1 pc 0 inst 0", b0.outValid, b0.outPC, b0.outInst); end
    tests++; if (b0.fetchState !== 2'd1 || b0.outPCPlus4 !== 32'h4) begin fails++; $display("FAIL run0_st got st%0d p4 %h want st1 p4 4", b0.fetchState, b0.outPCPlus4); end
    tick();
    tests++; if (b0.outPC !== 32'h4 || b0.outInst !== 32'h1) begin fails++; $display("FAIL run1 got pc %h inst %h want 4/1", b0.outPC, b0.outInst); end
    tick();
    tests++; if (b0.outPC !== 32'h8 || b0.outInst !== 32'h2) begin fails++; $display("FAIL run2 got pc %h inst %h want 8/2", b0.outPC, b0.outInst); end
  endtask

  task automatic test_stall();
    b0.isStall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (b0.outPC !== 32'h8 || b0.outInst !== 32'h2 || b0.fetchState !== 2'd2 || b0.outValid !== 1'b1)
        begin fails++; $display("FAIL stall%0d got pc %h inst %h st %0d want 8/2/2", i, b0.outPC, b0.outInst, b0.fetchState); end
    end
    b0.isStall = 0;
    tick();
    tests++; if (b0.outPC !== 32'hC || b0.outInst !== 32'h3 || b0.fetchState !== 2'd1) begin fails++; $display("FAIL stall_rel got pc %h inst %h st %0d want c/3/1", b0.outPC, b0.outInst, b0.fetchState); end
  endtask

  task automatic test_redirect();
    tick();
    tests++; if (b0.outPC !== 32'h10) begin fails++; $display("FAIL redir_pre got pc %h want 10", b0.outPC); end
    b0.redirectEn = 1; b0.redirectPC = 32'h103;
    tick();
    b0.redirectEn = 0;
    tests++; if (b0.outValid !== 1'b0 || b0.fetchState !== 2'd3) begin fails++; $display("FAIL redir_bub got v%0d st%0d want v0 st3", b0.outValid, b0.fetchState); end
    tick();
    tests++; if (b0.outValid !== 1'b1 || b0.outPC !== 32'h100 || b0.outInst !== 32'h40) begin fails++; $display("FAIL redir_tgt got v%0d pc %h inst %h want v1 100 40", b0.outValid, b0.outPC, b0.outInst); end
  endtask

  task automatic test_redirect_stall();
    b0.isStall = 1;
    tick();
    tests++; if (dut.skid_full_q !== 1'b1 || b0.outPC !== 32'h100) begin fails++; $display("FAIL rs_skid got full %0d pc %h want 1/100", dut.skid_full_q, b0.outPC); end
    b0.redirectEn = 1; b0.redirectPC = 32'h200;
    tick();
    tests++; if (dut.skid_full_q !== 1'b0 || b0.outValid !== 1'b0 || b0.fetchState !== 2'd3) begin fails++; $display("FAIL rs_redir got full %0d v%0d st%0d want 0/0/3", dut.skid_full_q, b0.outValid, b0.fetchState); end
    b0.redirectEn = 0; b0.isStall = 0;
    tick();
    tests++; if (b0.outPC !== 32'h200 || b0.outInst !== 32'h80 || b0.outValid !== 1'b1) begin fails++; $display("FAIL rs_tgt got pc %h inst %h v%0d want 200/80/1", b0.outPC, b0.outInst, b0.outValid); end
  endtask

  task automatic test_perf();
    reset = 0;
    #1;
    tests++; if (b0.outValid !== 1'b0 || b0.outPC !== 32'h0 || b0.fetchState !== 2'd0) begin fails++; $display("FAIL async_rst got v%0d pc %h st%0d want 0/0/0", b0.outValid, b0.outPC, b0.fetchState); end
    tests++; if (b0.stallCycles !== 32'h0 || b0.bubbleCycles !== 32'h0) begin fails++; $display("FAIL async_rst_cnt got %0d/%0d want 0/0", b0.stallCycles, b0.bubbleCycles); end
    @(negedge clk) reset = 1;
    tick(); tick();
    b0.isStall = 1;
    repeat (5) tick();
    b0.isStall = 0; b0.redirectEn = 1; b0.redirectPC = 32'h40;
    tick();
    b0.redirectEn = 0;
    tick(); tick();
    tests++; if (b0.stallCycles !== EXP_STALLS) begin fails++; $display("FAIL perf_stall got %0d want %0d", b0.stallCycles, EXP_STALLS); end
    tests++; if (b0.bubbleCycles !== EXP_BUBBLES) begin fails++; $display("FAIL perf_bubble got %0d want %0d", b0.bubbleCycles, EXP_BUBBLES); end
    tests++; if (b0.outPC !== 32'h44) begin fails++; $display("FAIL perf_pc got %h want 44", b0.outPC); end
  endtask

  task automatic test_wrap();
    reset = 0;
    #1;
    tests++; if (b1.imemAddr !== 11'd2047) begin fails++; $display("FAIL wrap_addr0 got %0d want 2047", b1.imemAddr); end
    @(negedge clk) reset = 1;
    tick();
    tests++; if (b1.outPC !== 32'hFFFF_FFFC || b1.outInst !== 32'd2047 || b1.imemAddr !== 11'd0) begin fails++; $display("FAIL wrap_first got pc %h inst %0d addr %0d want fffffffc/2047/0", b1.outPC, b1.outInst, b1.imemAddr); end
    tests++; if (b1.outPCPlus4 !== 32'h0) begin fails++; $display("FAIL wrap_p4 got %h want 0", b1.outPCPlus4); end
    tick();
    tests++; if (b1.outPC !== 32'h0 || b1.outInst !== 32'h0) begin fails++; $display("FAIL wrap_next got pc %h inst %h want 0/0", b1.outPC, b1.outInst); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_perf();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the two-stage pipeline. It owns the program counter, drives a synchronous instruction memory, and presents instruction, PC and valid to decode/execute, which feeds the pipeline register. It holds on `isStall` from the pipeline register, using a one-entry skid buffer, and restarts at a new PC on `redirectEn` (taken branch or JAL) with a single bubble.

## Interface
- `RESET_VALUE`, default 32'h0: PC fetched first after reset; bits [1:0] must be 0.
- `IMEM_AW`, default 11: instruction memory word-address width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock.
- `isStall`  in  1  hold request from the pipeline register.
- `redirectEn`  in  1  load `redirectPC` as the next fetch PC.
- `redirectPC`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `imemAddr`  out  IMEM_AW  word address, equal to `pcReg[IMEM_AW+1:2]`.
- `imemData`  in  32  instruction memory read data, valid the cycle after the address.
- `outInst`  out  32  instruction to decode.
- `outPC`  out  32  PC of `outInst`.
- `outPCPlus4`  out  32  `outPC + 4`, modulo 2^32.
- `outValid`  out  1  `outInst`/`outPC` describe a real instruction.
- `fetchState`  out  2  FSM state: BOOT=0, RUN=1, STALL=2, BUBBLE=3.
- `stallCycles`  out  32  stall counter (see Configuration).
- `bubbleCycles`  out  32  bubble counter (see Configuration).

## Operation
- Registers and reset values (reset low):
  - `pcReg` = RESET_VALUE.
  - `respPC` = 0.
  - `respValid` = 0.
  - `skidInst` = 0.
  - `skidFull` = 0.
  - state = BOOT.
  - Counters = 0.
- Outputs:
  - `outInst` = `skidFull ? skidInst : imemData`.
  - `outPC` = `respPC`.
  - `outValid` = `respValid`.
- Priority per edge: `redirectEn` first, then `isStall`, then advance.
- Redirect: `pcReg` <= {redirectPC[31:2],2'b0}; `respValid` <= 0; `skidFull` <= 0; state <= BUBBLE. The in-flight fetch is discarded. A redirect overrides a simultaneous stall.
- Stall, no redirect:
  - `pcReg`, `respPC` and `respValid` hold.
  - If `respValid` && !`skidFull`: `skidInst` <= imemData and `skidFull` <= 1.
  - State <= STALL if `respValid`, otherwise it holds.
- Advance (neither redirect nor stall):
  - `respPC` <= pcReg; `respValid` <= 1; `skidFull` <= 0.
  - `pcReg` <= pcReg + 4.
  - State <= RUN.
- State transitions:
  - BOOT: on advance -> RUN.
  - RUN: on stall with `respValid` -> STALL.
  - Any state: on redirect -> BUBBLE.
  - STALL: on stall release -> RUN.
  - BUBBLE: on advance -> RUN.
- `imemAddr` is always derived from `pcReg`. During a stall the memory rereads `pcReg`, so the data for `respPC` is taken from the skid register.
- Arithmetic:
  - PC wraps modulo 2^32.
  - `imemAddr` wraps modulo 2^IMEM_AW words.
  - The upper PC bits are not checked.

## Timing
- Fetch latency: 1 cycle from `imemAddr` to `outValid`.
- After reset deasserts, the first edge registers the request. `outValid`=1 with `outPC`=RESET_VALUE follows one cycle later.
- Throughput: 1 instruction per cycle when there is no stall.
- Redirect penalty:
  - One cycle with `outValid`=0.
  - `outPC`=target on the second cycle after the redirect edge.
- Stall: `outInst`/`outPC` stay stable for every stalled cycle. The next sequential instruction appears the cycle after `isStall` falls.
- Reset mid-operation clears all state immediately, asynchronously. The skid contents are lost.

## Configuration
- `FETCH_PERF_EN` defined:
  - `stallCycles` increments every edge with `isStall`=1 and `redirectEn`=0.
  - `bubbleCycles` increments every edge where state is BUBBLE.
  - Both wrap at 2^32 and clear on reset.
- `FETCH_PERF_EN` undefined: both ports are tied to 32'h0 and no counter flops are built. The port list is unchanged.

## Test plan
- Reset low for 3 cycles, then release; memory returns word address as data -> `outValid`=1, `outPC`=0, `outInst`=0 one cycle after the first edge; then `outPC`=4, 8, 12 on consecutive cycles.
- `isStall`=1 for 3 cycles while `outPC`=8 -> `outInst` stays 2 and `outPC` stays 8, with `fetchState`=STALL. Release -> `outPC`=12, `outInst`=3.
- `redirectEn`=1 with `redirectPC`=32'h103 while `outPC`=16 -> next cycle `outValid`=0 and BUBBLE; following cycle `outPC`=32'h100.
- `redirectEn` and `isStall` both 1 at the same edge -> the redirect takes effect, `skidFull`=0, and `outPC`=target two cycles later.
- RESET_VALUE=32'hFFFF_FFFC -> next `outPC`=0; with IMEM_AW=11, `imemAddr` goes 2047 -> 0.
- With `FETCH_PERF_EN`: 5 stall cycles and 1 redirect -> `stallCycles`=5, `bubbleCycles`=1. Without it, both read 0.
